// File: rtl/leaf_req_if.sv
// leaf_req_if: comparison, leaf-lookup and verdict handshakes between leaf_req and its neighbours.
interface leaf_req_if #(
    parameter int W_LEAF      = 13,
    parameter int FEATURE_NUM = 2913,
    parameter int W_ACC       = 16,
    parameter int STAGE_NUM   = 25
);
    localparam int W_ADDR  = $clog2(FEATURE_NUM);
    localparam int W_STAGE = $clog2(STAGE_NUM);
    logic                      cmp_valid;
    logic                      cmp_ready;
    logic [W_ADDR-1:0]         cmp_addr;
    logic                      cmp_leaf;
    logic                      cmp_last;
    logic signed [W_ACC-1:0]   cmp_thr;
    logic                      leaf_addr_valid;
    logic                      leaf_addr_ready;
    logic [W_ADDR-1:0]         leaf_addr;
    logic                      leaf_num;
    logic                      leaf_data_valid;
    logic                      leaf_data_ready;
    logic signed [W_LEAF-1:0]  leaf_data;
    logic                      res_valid;
    logic                      res_ready;
    logic                      res_pass;
    logic [W_STAGE-1:0]        res_stage;
    modport master (
        input  cmp_valid, cmp_addr, cmp_leaf, cmp_last, cmp_thr,
        input  leaf_addr_ready, leaf_data_valid, leaf_data, res_ready,
        output cmp_ready, leaf_addr_valid, leaf_addr, leaf_num,
        output leaf_data_ready, res_valid, res_pass, res_stage
    );
    modport slave (
        output cmp_valid, cmp_addr, cmp_leaf, cmp_last, cmp_thr,
        output leaf_addr_ready, leaf_data_valid, leaf_data, res_ready,
        input  cmp_ready, leaf_addr_valid, leaf_addr, leaf_num,
        input  leaf_data_ready, res_valid, res_pass, res_stage
    );
endinterface

// File: rtl/leaf_req.sv
// leaf_req: requests one leaf value per weak classifier, accumulates it with saturation
// and reports a signed pass/fail verdict at the end of each stage.
module leaf_req #(
    parameter int W_LEAF      = 13,
    parameter int FEATURE_NUM = 2913,
    parameter int W_ACC       = 16,
    parameter int STAGE_NUM   = 25
) (
    input logic        clk,
    input logic        rst,
    leaf_req_if.master lr
);
    localparam int W_ADDR  = $clog2(FEATURE_NUM);
    localparam int W_STAGE = $clog2(STAGE_NUM);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RES = 2'd3;
    logic [1:0]               state_q, state_d;
    logic [W_ADDR-1:0]        addr_q;
    logic                     leaf_q, last_q, pass_q;
    logic signed [W_ACC-1:0]  thr_q, acc_q, acc_d;
    logic signed [W_ACC:0]    sum;
    logic signed [W_LEAF-1:0] leaf_v;
    logic [W_STAGE-1:0]       stage_q, res_stage_q;
    logic                     cmp_hs, data_hs, res_hs;
    assign leaf_v  = lr.leaf_data;
    assign cmp_hs  = lr.cmp_valid & lr.cmp_ready;
    assign data_hs = (state_q == WAIT) & lr.leaf_data_valid;
    assign res_hs  = (state_q == RES) & lr.res_ready;
    // cmp_ready is gated by rst so every output reads 0 while reset is held
    assign lr.cmp_ready       = rst & (state_q == IDLE);
    assign lr.leaf_addr_valid = state_q == REQ;
    assign lr.leaf_data_ready = state_q == WAIT;
    assign lr.res_valid       = state_q == RES;
    assign lr.leaf_addr       = addr_q;
    assign lr.leaf_num        = leaf_q;
    assign lr.res_pass        = pass_q;
    assign lr.res_stage       = res_stage_q;
    always_comb begin
        sum     = (W_ACC+1)'(acc_q) + (W_ACC+1)'(leaf_v);
        acc_d   = (sum[W_ACC] != sum[W_ACC-1]) ?
                  (sum[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}}) :
                  sum[W_ACC-1:0];
        state_d = (state_q == IDLE && cmp_hs)             ? REQ  :
                  (state_q == REQ && lr.leaf_addr_ready)  ? WAIT :
                  data_hs                                 ? (last_q ? RES : IDLE) :
                  res_hs                                  ? IDLE : state_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            leaf_q      <= 1'b0;
            last_q      <= 1'b0;
            thr_q       <= '0;
            acc_q       <= '0;
            pass_q      <= 1'b0;
            stage_q     <= '0;
            res_stage_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmp_hs) begin
                addr_q <= lr.cmp_addr;
                leaf_q <= lr.cmp_leaf;
                last_q <= lr.cmp_last;
                if (lr.cmp_last) thr_q <= lr.cmp_thr;
            end
            if (data_hs) begin
                acc_q <= last_q ? '0 : acc_d;
                if (last_q) begin
                    pass_q      <= acc_d >= thr_q;
                    res_stage_q <= stage_q;
                end
            end
            if (res_hs) stage_q <= (stage_q == W_STAGE'(STAGE_NUM-1)) ? '0 : stage_q + W_STAGE'(1);
        end
    end
endmodule

// File: tb/tb_leaf_req.sv
// tb_leaf_req: randomized and directed stages against an integer reference of the
// saturating stage sum, verdict and wrapping stage index.
module tb_leaf_req;
    localparam int LIM = 32768;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int acc_m = 0;
    int stage_m = 0;
    always #5 clk = ~clk;
    leaf_req_if #(.W_LEAF(13), .FEATURE_NUM(2913), .W_ACC(16), .STAGE_NUM(25)) lr();
    leaf_req #(.W_LEAF(13), .FEATURE_NUM(2913), .W_ACC(16), .STAGE_NUM(25)) dut (
        .clk(clk),
        .rst(rst),
        .lr (lr.master)
    );
    function automatic int sat(input int x);
        return (x > LIM - 1) ? LIM - 1 : (x < -LIM) ? -LIM : x;
    endfunction
    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    task automatic zero_chk(input string t);
        check({t, "_cmp_ready"}, lr.cmp_ready, 0);
        check({t, "_addr_valid"}, lr.leaf_addr_valid, 0);
        check({t, "_addr"}, lr.leaf_addr, 0);
        check({t, "_num"}, lr.leaf_num, 0);
        check({t, "_data_ready"}, lr.leaf_data_ready, 0);
        check({t, "_res_valid"}, lr.res_valid, 0);
        check({t, "_res_pass"}, lr.res_pass, 0);
        check({t, "_res_stage"}, lr.res_stage, 0);
    endtask
    // One weak classifier: beat, request (as stall cycles), data (ds stall cycles), verdict (rs stall cycles)
    task automatic beat(input int val, input bit last, input int thr, input int as, input int ds, input int rs);
        logic [11:0] a;
        logic l;
        int n;
        a = 12'($urandom_range(0, 2912));
        l = 1'($urandom);
        lr.cmp_valid = 1'b1;
        lr.cmp_addr  = a;
        lr.cmp_leaf  = l;
        lr.cmp_last  = last;
        lr.cmp_thr   = last ? 16'(thr) : 16'($urandom);
        n = 0;
        while (!lr.cmp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmp_accept", n < 50, 1);
        @(negedge clk);
        lr.cmp_valid = 1'b0;
        lr.cmp_addr  = ~a;
        lr.cmp_leaf  = ~l;
        lr.cmp_last  = 1'b0;
        lr.cmp_thr   = 16'($urandom);
        for (int k = 0; k <= as; k++) begin
            check("req_valid", lr.leaf_addr_valid, 1);
            check("req_addr", lr.leaf_addr, a);
            check("req_num", lr.leaf_num, l);
            check("req_cmp_busy", lr.cmp_ready, 0);
            if (k == as) lr.leaf_addr_ready = 1'b1;
            @(negedge clk);
        end
        lr.leaf_addr_ready = 1'b0;
        for (int k = 0; k <= ds; k++) begin
            check("wait_ready", lr.leaf_data_ready, 1);
            check("wait_addr", lr.leaf_addr, a);
            check("wait_num", lr.leaf_num, l);
            check("wait_no_req", lr.leaf_addr_valid, 0);
            check("wait_cmp_busy", lr.cmp_ready, 0);
            lr.leaf_data_valid = (k == ds);
            lr.leaf_data = (k == ds) ? 13'(val) : 13'($urandom);
            @(negedge clk);
        end
        lr.leaf_data_valid = 1'b0;
        lr.leaf_data = 13'($urandom);
        acc_m = sat(acc_m + val);
        if (!last) begin
            check("idle_ready", lr.cmp_ready, 1);
            check("no_verdict", lr.res_valid, 0);
        end else begin
            lr.cmp_valid = rs > 0;
            for (int k = 0; k <= rs; k++) begin
                check("res_valid", lr.res_valid, 1);
                check("res_pass", lr.res_pass, acc_m >= thr);
                check("res_stage", lr.res_stage, stage_m);
                check("res_cmp_blocked", lr.cmp_ready, 0);
                if (k == rs) begin
                    lr.res_ready = 1'b1;
                    lr.cmp_valid = 1'b0;
                end
                @(negedge clk);
            end
            lr.res_ready = 1'b0;
            check("res_done", lr.res_valid, 0);
            check("res_idle", lr.cmp_ready, 1);
            stage_m = (stage_m + 1) % 25;
            acc_m = 0;
        end
    endtask
    task automatic stage(input int v[$], input int thr, input int as, input int ds, input int rs);
        foreach (v[i]) beat(v[i], i == v.size() - 1, thr, as, ds, rs);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
    initial begin
        int q[$];
        int s, thr;
        lr.cmp_valid = 0; lr.cmp_addr = 0; lr.cmp_leaf = 0; lr.cmp_last = 0; lr.cmp_thr = 0;
        lr.leaf_addr_ready = 0; lr.leaf_data_valid = 0; lr.leaf_data = 0; lr.res_ready = 0;
        #1;
        zero_chk("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q = {100, -30, 50};
        stage(q, 100, 0, 0, 0);
        stage(q, 121, 0, 0, 0);
        stage(q, 120, 0, 0, 0);
        q = {20, 20};
        stage(q, 0, 4, 3, 5);
        q = {4095, 4095, 4095, 4095};
        stage(q, 16000, 0, 0, 0);
        q = {-4096, -4096, -4096, -4096};
        stage(q, -16384, 0, 0, 0);
        q = {};
        repeat (9) q.push_back(4095);
        q.push_back(-100);
        stage(q, 32667, 0, 0, 0);
        stage(q, 32668, 0, 0, 0);
        q = {};
        repeat (9) q.push_back(-4096);
        q.push_back(100);
        stage(q, -32668, 0, 0, 0);
        stage(q, -32667, 0, 0, 0);
        for (int n = 0; n < 30; n++) begin
            q = {};
            repeat ($urandom_range(1, 4)) q.push_back(int'($urandom_range(0, 8191)) - 4096);
            s = 0;
            foreach (q[i]) s = sat(s + q[i]);
            thr = $urandom_range(0, 1) ? s + int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 40000)) - 20000;
            stage(q, thr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        beat(500, 0, 0, 0, 0, 0);
        lr.cmp_valid = 1; lr.cmp_addr = 12'd77; lr.cmp_leaf = 1; lr.cmp_last = 1; lr.cmp_thr = 0;
        @(negedge clk);
        lr.cmp_valid = 0;
        lr.leaf_addr_ready = 1;
        @(negedge clk);
        lr.leaf_addr_ready = 0;
        check("pre_rst_wait", lr.leaf_data_ready, 1);
        #2 rst = 1'b0;
        #1 zero_chk("async_rst");
        lr.leaf_data_valid = 1;
        lr.leaf_data = 13'(1234);
        @(negedge clk);
        zero_chk("held_rst");
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_no_data_ready", lr.leaf_data_ready, 0);
        check("post_rst_ready", lr.cmp_ready, 1);
        lr.leaf_data_valid = 0;
        acc_m = 0;
        stage_m = 0;
        q = {-7};
        stage(q, -6, 0, 0, 0);
        q = {5};
        stage(q, 5, 1, 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
